// File: rtl/updown_counter_gen.sv
// Prescaled up/down modulo counter with run/stop, load/clear, wrap flag and LED chaser.
// Define UPDOWN_SATURATE_EN to saturate at 0/CNT_MAX instead of wrapping.
module updown_counter_gen #(
  parameter int PRESCALE_DIV = 1000000,
  parameter int CNT_WIDTH    = 14,
  parameter int CNT_MAX      = 9999,
  parameter int LED_WIDTH    = 8
) (
  input  logic                 sysclk,
  input  logic                 i_rst,
  input  logic                 i_run_tgl,
  input  logic                 i_dir,
  input  logic                 i_clr,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_load_val,
  output logic [CNT_WIDTH-1:0] o_counter,
  output logic                 o_tick,
  output logic                 o_wrap,
  output logic                 o_running,
  output logic [LED_WIDTH-1:0] o_upcLED
);

  localparam int PW = $clog2(PRESCALE_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] C_MAX = CNT_WIDTH'(CNT_MAX);
  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);
  localparam logic [LED_WIDTH-1:0] LED_RST = LED_WIDTH'(1);

  localparam logic [0:0] STOP = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]           state;
  logic [0:0]           state_nxt;
  logic [PW-1:0]        presc;
  logic                 tick_evt;
  logic                 at_lim;
  logic                 step_move;
  logic [CNT_WIDTH-1:0] cnt_step;
  logic [CNT_WIDTH-1:0] load_sat;
  logic [LED_WIDTH-1:0] led_step;

  always_comb begin
    tick_evt  = (state == RUN) && (presc == P_LAST);
    state_nxt = i_run_tgl ? ~state : state;
    load_sat  = (i_load_val > C_MAX) ? C_MAX : i_load_val;
    at_lim    = i_dir ? (o_counter == C_MAX)
                      : (o_counter == '0);
    led_step  = i_dir
      ? {o_upcLED[LED_WIDTH-2:0], o_upcLED[LED_WIDTH-1]}
      : {o_upcLED[0], o_upcLED[LED_WIDTH-1:1]};
`ifdef UPDOWN_SATURATE_EN
    step_move = !at_lim;
    if (at_lim)
      cnt_step = o_counter;
    else
      cnt_step = i_dir ? o_counter + C_ONE
                       : o_counter - C_ONE;
`else
    step_move = 1'b1;
    if (at_lim)
      cnt_step = i_dir ? '0 : C_MAX;
    else
      cnt_step = i_dir ? o_counter + C_ONE
                       : o_counter - C_ONE;
`endif
  end

  // Leaving RUN or a clear both restart the tick period from zero.
  always_ff @(posedge sysclk or posedge i_rst) begin
    if (i_rst) begin
      state     <= STOP;
      o_running <= 1'b0;
      presc     <= '0;
    end else begin
      state     <= state_nxt;
      o_running <= (state_nxt == RUN);
      if (i_clr || state == STOP || i_run_tgl || tick_evt)
        presc <= '0;
      else
        presc <= presc + PW'(1);
    end
  end

  // Clear beats load beats tick; a discarded tick still shows on o_tick.
  always_ff @(posedge sysclk or posedge i_rst) begin
    if (i_rst) begin
      o_counter <= '0;
      o_tick    <= 1'b0;
      o_wrap    <= 1'b0;
      o_upcLED  <= LED_RST;
    end else begin
      o_tick <= tick_evt;
      o_wrap <= 1'b0;
      if (i_clr) begin
        o_counter <= '0;
        o_upcLED  <= LED_RST;
      end else if (i_load) begin
        o_counter <= load_sat;
      end else if (tick_evt) begin
        o_counter <= cnt_step;
        o_wrap    <= at_lim;
        if (step_move)
          o_upcLED <= led_step;
      end
    end
  end

endmodule

// File: tb/tb_updown_counter_gen.sv
// Scoreboard bench for updown_counter_gen: expected tick results are queued
// by the stimulus and popped by a monitor on every o_tick.
module tb_updown_counter_gen;

  localparam int PD = 4;
  localparam int CW = 4;
  localparam int CM = 9;
  localparam int LW = 4;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          wrap;
    logic [LW-1:0] led;
  } exp_t;

  logic          sysclk;
  logic          i_rst;
  logic          i_run_tgl;
  logic          i_dir;
  logic          i_clr;
  logic          i_load;
  logic [CW-1:0] i_load_val;
  logic [CW-1:0] o_counter;
  logic          o_tick;
  logic          o_wrap;
  logic          o_running;
  logic [LW-1:0] o_upcLED;

  exp_t q[$];
  exp_t em;
  int   errors = 0;
  int   checks = 0;
  int   ticks  = 0;
  int   lat;
  int   t0;

  updown_counter_gen #(
    .PRESCALE_DIV(PD),
    .CNT_WIDTH(CW),
    .CNT_MAX(CM),
    .LED_WIDTH(LW)
  ) dut (
    .sysclk(sysclk),
    .i_rst(i_rst),
    .i_run_tgl(i_run_tgl),
    .i_dir(i_dir),
    .i_clr(i_clr),
    .i_load(i_load),
    .i_load_val(i_load_val),
    .o_counter(o_counter),
    .o_tick(o_tick),
    .o_wrap(o_wrap),
    .o_running(o_running),
    .o_upcLED(o_upcLED)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int c, input int w, input int l);
    exp_t e;
    e.cnt  = CW'(c);
    e.wrap = w[0];
    e.led  = LW'(l);
    q.push_back(e);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(posedge sysclk);
      #1;
      n++;
    end while (!o_tick && n < 20);
    if (!o_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no o_tick within %0d cycles", n);
    end
  endtask

  always @(negedge sysclk) begin
    if (!i_rst && o_wrap && !o_tick) begin
      checks++;
      errors++;
      $display("FAIL wrap_no_tick: o_wrap=1 with o_tick=0");
    end
    if (!i_rst && o_tick) begin
      ticks++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: cnt=%0d wrap=%0b led=%b",
                 o_counter, o_wrap, o_upcLED);
      end else begin
        em = q.pop_front();
        if ({o_counter, o_wrap, o_upcLED} !== em) begin
          errors++;
          $display("FAIL tick_%0d: got cnt=%0d wrap=%0b led=%b expected cnt=%0d wrap=%0b led=%b",
                   ticks, o_counter, o_wrap, o_upcLED, em.cnt, em.wrap, em.led);
        end
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    i_run_tgl = 1'b0;
    i_dir = 1'b1;
    i_clr = 1'b0;
    i_load = 1'b0;
    i_load_val = '0;
    repeat (2) @(posedge sysclk);
    #1;
    chk("rst_counter", int'(o_counter), 0);
    chk("rst_tick", int'(o_tick), 0);
    chk("rst_wrap", int'(o_wrap), 0);
    chk("rst_running", int'(o_running), 0);
    chk("rst_led", int'(o_upcLED), 1);
    i_rst = 1'b0;

    // run up from zero
    push(1, 0, 4'b0010);
    push(2, 0, 4'b0100);
    push(3, 0, 4'b1000);
    push(4, 0, 4'b0001);
    i_run_tgl = 1'b1;
    @(posedge sysclk);
    #1;
    i_run_tgl = 1'b0;
    wait_tick(lat);
    chk("first_tick_latency", lat, 4);
    for (int i = 0; i < 3; i++) begin
      wait_tick(lat);
      chk("tick_period", lat, 4);
    end

    // up wrap / saturate
`ifdef UPDOWN_SATURATE_EN
    push(9, 0, 4'b0010);
    push(9, 1, 4'b0010);
    push(9, 1, 4'b0010);
`else
    push(9, 0, 4'b0010);
    push(0, 1, 4'b0100);
    push(1, 0, 4'b1000);
`endif
    i_load = 1'b1;
    i_load_val = 4'd8;
    @(posedge sysclk);
    #1;
    i_load = 1'b0;
    repeat (3) wait_tick(lat);

    // down wrap / saturate
`ifdef UPDOWN_SATURATE_EN
    push(0, 0, 4'b0001);
    push(0, 1, 4'b0001);
    push(0, 1, 4'b0001);
`else
    push(0, 0, 4'b0100);
    push(9, 1, 4'b0010);
    push(8, 0, 4'b0001);
`endif
    i_load = 1'b1;
    i_load_val = 4'd1;
    i_dir = 1'b0;
    @(posedge sysclk);
    #1;
    i_load = 1'b0;
    repeat (3) wait_tick(lat);

    // one step up so the LED is off bit0 before the clear
    i_dir = 1'b1;
`ifdef UPDOWN_SATURATE_EN
    push(1, 0, 4'b0010);
`else
    push(9, 0, 4'b0010);
`endif
    wait_tick(lat);

    // clear and load coincident with a tick
    push(0, 0, 4'b0001);
    repeat (3) @(posedge sysclk);
    #1;
    i_clr = 1'b1;
    i_load = 1'b1;
    i_load_val = 4'd5;
    @(posedge sysclk);
    #1;
    chk("prio_tick", int'(o_tick), 1);
    i_clr = 1'b0;
    i_load = 1'b0;

    // stop, clamped load, no ticks while stopped
    i_run_tgl = 1'b1;
    @(posedge sysclk);
    #1;
    i_run_tgl = 1'b0;
    chk("stop_running", int'(o_running), 0);
    i_load = 1'b1;
    i_load_val = 4'd15;
    @(posedge sysclk);
    #1;
    i_load = 1'b0;
    chk("load_clamp", int'(o_counter), 9);
    t0 = ticks;
    repeat (20) @(posedge sysclk);
    #1;
    chk("stop_no_tick", ticks - t0, 0);

`ifdef UPDOWN_SATURATE_EN
    push(9, 1, 4'b0001);
`else
    push(0, 1, 4'b0010);
`endif
    i_run_tgl = 1'b1;
    @(posedge sysclk);
    #1;
    i_run_tgl = 1'b0;
    wait_tick(lat);
    chk("restart_latency", lat, 4);
    chk("run_running", int'(o_running), 1);

    // reach 6, then async reset between edges
`ifdef UPDOWN_SATURATE_EN
    push(6, 0, 4'b0010);
`else
    push(6, 0, 4'b0100);
`endif
    i_load = 1'b1;
    i_load_val = 4'd5;
    @(posedge sysclk);
    #1;
    i_load = 1'b0;
    wait_tick(lat);
    chk("pre_rst_counter", int'(o_counter), 6);
    @(posedge sysclk);
    #3;
    i_rst = 1'b1;
    #1;
    chk("async_counter", int'(o_counter), 0);
    chk("async_running", int'(o_running), 0);
    chk("async_led", int'(o_upcLED), 1);
    @(posedge sysclk);
    #1;
    i_rst = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_counter_gen.md
Name: updown_counter_gen

Overview:
Parametrised successor of the 100 Hz up-counter block, in a single clock domain. An internal prescaler produces a one-cycle tick enable; no derived clock is generated. On each tick a modulo-N counter steps up or down. The block adds run/stop control, synchronous load/clear, a wrap flag and a rotating LED chaser, and drives the 7-segment counter value and LED bar at board top level.

Parameters:
PRESCALE_DIV, 1000000, sysclk cycles per tick (100 MHz -> 100 Hz); must be >= 2
CNT_WIDTH, 14, counter output width
CNT_MAX, 9999, terminal count; counter range 0..CNT_MAX; must be < 2^CNT_WIDTH
LED_WIDTH, 8, LED chaser width; must be >= 2

Ports:
sysclk  input  1  system clock, all logic on rising edge
i_rst  input  1  asynchronous, active-high reset
i_run_tgl  input  1  one-cycle pulse; toggles STOP<->RUN
i_dir  input  1  1 = count up, 0 = count down; sampled on each tick
i_clr  input  1  synchronous clear pulse
i_load  input  1  synchronous load pulse
i_load_val  input  CNT_WIDTH  load value; values > CNT_MAX are clamped to CNT_MAX
o_counter  output  CNT_WIDTH  current count
o_tick  output  1  one-cycle pulse when the prescaler expires (RUN only)
o_wrap  output  1  one-cycle pulse on the cycle the counter wraps (or saturates)
o_running  output  1  1 while in RUN
o_upcLED  output  LED_WIDTH  one-hot chaser

Behaviour:
- Reset (async assert, released synchronously to sysclk):
  - state=STOP, prescaler=0, o_counter=0, o_tick=0, o_wrap=0, o_running=0
  - o_upcLED = {LED_WIDTH-1 zeros, 1} (bit0 lit)
- FSM states: STOP, RUN.
  - i_run_tgl=1 toggles the state on the next edge.
  - o_running is registered and equals (state==RUN).
- Prescaler:
  - Counts 0..PRESCALE_DIV-1 only in RUN.
  - On reaching PRESCALE_DIV-1: returns to 0 and o_tick=1 for one cycle.
  - In STOP: held at 0. The first tick therefore occurs exactly PRESCALE_DIV cycles after the cycle RUN is entered.
- Counter update priority (highest first): i_clr > i_load > tick.
  - clr: o_counter=0; prescaler=0; LED chaser reset to bit0; no o_wrap.
  - load: o_counter=min(i_load_val, CNT_MAX); prescaler unchanged; no o_wrap. Clr and load are honoured in STOP and RUN.
  - tick, i_dir=1: o_counter+1. If at CNT_MAX, goes to 0 and o_wrap=1.
  - tick, i_dir=0: o_counter-1. If at 0, goes to CNT_MAX and o_wrap=1.
  - A tick coinciding with clr or load is discarded.
- o_tick and o_wrap are registered, asserted in the same cycle that o_counter takes its new value. o_tick still pulses when a coincident clr/load discards the step.
- LED chaser:
  - Rotates one position per applied tick: left when i_dir=1, right when i_dir=0, wrapping at the ends.
  - Exactly one bit is high at all times.
- i_run_tgl coinciding with a tick: the tick is applied, then the state toggles.
- Reset mid-count: everything returns to reset values immediately (asynchronous).

Optional Feature:
Macro: UPDOWN_SATURATE_EN
- Defined: the counter saturates instead of wrapping.
  - Up at CNT_MAX stays at CNT_MAX; down at 0 stays at 0.
  - o_wrap pulses on every tick attempted at the limit.
  - LED chaser does not rotate on a saturated tick.
- Undefined: modulo wrap as described in Behaviour.

Test Plan:
Bench parameters: PRESCALE_DIV=4, CNT_MAX=9, LED_WIDTH=4.
- Reset then run: i_rst pulse, i_run_tgl pulse, i_dir=1 -> o_tick every 4 cycles; o_counter 0,1,2,... ; o_upcLED 0001->0010->0100->1000->0001.
- Up wrap: load 8, run up -> 8,9,0 with o_wrap=1 on the 9->0 cycle only.
  - With UPDOWN_SATURATE_EN: 8,9,9,9 with o_wrap on each tick at 9.
- Down wrap: load 1, i_dir=0 -> 1,0,9 with o_wrap on the 0->9 cycle; LED rotates right.
- Priority: assert i_clr and i_load (val=5) together with a tick -> o_counter=0, no o_wrap, LED=0001.
- Load clamp and stop: in STOP, load 15 -> o_counter=9; no o_tick for 20 cycles. Toggle to RUN -> first o_tick exactly 4 cycles later.
- Async reset mid-run at count 6: assert i_rst between clock edges -> o_counter=0, o_running=0 without waiting for an edge.
